// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_arb_pkg;

   // Default data width of every stream.
   localparam int WIDTH_DEF = 32;

   // Output register occupancy.
   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_e;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating priority select: first set req bit searching upward from ptr+1, wrapping at N-1.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller qualifies the grant with its own load condition.
module rr_priority_select #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] grant,
   output logic             grant_vld
);

   // Walk candidates from the farthest to the nearest so the nearest requester wins.
   always_comb begin
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      grant     = '0;
      grant_vld = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = N; k >= 1; k--) begin
         // ptr+k never exceeds 2N-1, so a single conditional subtract wraps it.
         sum = {1'b0, ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
         idx = sum[PTR_W-1:0];
         if (req[idx]) begin
            grant     = idx;
            grant_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_round_robin_arbiter.sv
// Round-robin merge of N stb/ack streams onto one registered output, with optional burst hold.
// Latency: 1 cycle from input accept to out_stb; sustains 1 word/cycle with out_ack high.
// Backpressure: out_ack low with a word held freezes all state and forces in_ack to 0.
module stream_round_robin_arbiter
   import stream_arb_pkg::*;
#(
   parameter int N         = 4,
   parameter int WIDTH     = WIDTH_DEF,
   parameter int MAX_BURST = 1,
   parameter int SRC_W     = (clog2(N) > 1) ? clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_stb,
   output logic [N-1:0]       in_ack,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_stb,
   input  logic               out_ack,
   output logic [SRC_W-1:0]   out_src
);

   localparam int BURST_W = (clog2(MAX_BURST + 1) > 1) ? clog2(MAX_BURST + 1) : 1;

   arb_state_e         state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SRC_W-1:0]   src_q, src_d;
   logic [SRC_W-1:0]   last_q, last_d;
   logic [BURST_W-1:0] burst_q, burst_d;

   logic [SRC_W-1:0]   rr_idx;
   logic               rr_vld;
   logic               hold;
   logic [SRC_W-1:0]   gnt;
   logic               gnt_vld;
   logic               can_load;
   logic               load;
   logic [WIDTH-1:0]   gnt_data;

   rr_priority_select #(
      .N     (N),
      .PTR_W (SRC_W)
   ) u_rr_sel (
      .req       (in_stb),
      .ptr       (last_q),
      .grant     (rr_idx),
      .grant_vld (rr_vld)
   );

   // A nonzero burst count means a previous grant exists; keep it while the burst budget lasts.
   assign hold     = (burst_q != '0) && (burst_q < BURST_W'(MAX_BURST)) && in_stb[last_q];
   assign gnt      = hold ? last_q : rr_idx;
   assign gnt_vld  = hold || rr_vld;
   assign can_load = (state_q == IDLE) || out_ack;
   assign load     = can_load && gnt_vld;

   // One-hot accept for the granted requester; reset forces it low regardless of register state.
   always_comb begin
      in_ack = '0;
      for (int i = 0; i < N; i++) begin
         in_ack[i] = rst && load && (gnt == SRC_W'(i));
      end
   end

   // Pick the granted requester's word out of the flattened input bus.
   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt == SRC_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Next-state: load a new word, drain to IDLE, or hold under backpressure.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      src_d   = src_q;
      last_d  = last_q;
      burst_d = burst_q;
      if (load) begin
         state_d = SEND;
         data_d  = gnt_data;
         src_d   = gnt;
         last_d  = gnt;
         if (gnt == last_q) begin
            if (burst_q != BURST_W'(MAX_BURST)) burst_d = burst_q + BURST_W'(1);
         end else begin
            burst_d = BURST_W'(1);
         end
      end else if ((state_q == SEND) && out_ack) begin
         state_d = IDLE;
      end
   end

   // State and output registers; reset discards any held word and gives requester 0 first priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         src_q   <= '0;
         last_q  <= SRC_W'(N - 1);
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         src_q   <= src_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   assign out_stb  = (state_q == SEND);
   assign out_data = data_q;
   assign out_src  = src_q;

endmodule

// File: tb/tb_stream_round_robin_arbiter.sv
// Randomized bench for two arbiter instances (pure round-robin and burst of 3) against a reference model.
// Latency: model expects words one cycle after acceptance.
// Backpressure: producers hold stb/data until acked; out_ack is randomized per phase.
module tb_stream_round_robin_arbiter;

   localparam int NR = 4;
   localparam int W  = 32;

   logic            clk;
   logic            rst;
   logic [NR-1:0]   stb  [2];
   logic [NR*W-1:0] din  [2];
   logic            oack [2];
   logic [NR-1:0]   iack [2];
   logic [W-1:0]    odat [2];
   logic            ostb [2];
   logic [1:0]      osrc [2];

   int checks;
   int errors;

   // Reference model state per instance: held word, its source, last grant, burst count.
   bit            m_hold [2];
   logic [W-1:0]  m_data [2];
   int            m_src  [2];
   int            m_last [2];
   int            m_cnt  [2];
   int            m_mb   [2];
   logic [NR-1:0] m_acked [2];

   stream_round_robin_arbiter #(.N(NR), .WIDTH(W), .MAX_BURST(1)) u_dut_a (
      .clk      (clk),
      .rst      (rst),
      .in_data  (din[0]),
      .in_stb   (stb[0]),
      .in_ack   (iack[0]),
      .out_data (odat[0]),
      .out_stb  (ostb[0]),
      .out_ack  (oack[0]),
      .out_src  (osrc[0])
   );

   stream_round_robin_arbiter #(.N(NR), .WIDTH(W), .MAX_BURST(3)) u_dut_b (
      .clk      (clk),
      .rst      (rst),
      .in_data  (din[1]),
      .in_stb   (stb[1]),
      .in_ack   (iack[1]),
      .out_data (odat[1]),
      .out_stb  (ostb[1]),
      .out_ack  (oack[1]),
      .out_src  (osrc[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset(int k);
      m_hold[k]  = 1'b0;
      m_data[k]  = '0;
      m_src[k]   = 0;
      m_last[k]  = NR - 1;
      m_cnt[k]   = 0;
      m_acked[k] = '0;
   endfunction

   // Grant rule: keep the last requester while its burst budget lasts, else nearest after last.
   function automatic int model_grant(int k, logic [NR-1:0] s);
      if (m_cnt[k] > 0 && m_cnt[k] < m_mb[k] && s[m_last[k]]) return m_last[k];
      for (int d = 1; d <= NR; d++) begin
         if (s[(m_last[k] + d) % NR]) return (m_last[k] + d) % NR;
      end
      return -1;
   endfunction

   // Producers keep an unaccepted word; otherwise they may offer a fresh one.
   task automatic drive(int k, logic [NR-1:0] mask, int p_stb, int p_ack);
      for (int i = 0; i < NR; i++) begin
         if (!(stb[k][i] && !m_acked[k][i])) begin
            stb[k][i]         = mask[i] && ($urandom_range(99) < p_stb);
            din[k][i*W +: W]  = $urandom;
         end
      end
      oack[k] = ($urandom_range(99) < p_ack);
   endtask

   task automatic run_cycle(logic [NR-1:0] mask, int p_stb, int p_ack);
      int g [2];
      bit ld [2];
      logic [NR-1:0] ea;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("out_stb[%0d]", k), 64'(ostb[k]), 64'(m_hold[k]));
         if (m_hold[k]) begin
            check_eq($sformatf("out_data[%0d]", k), 64'(odat[k]), 64'(m_data[k]));
            check_eq($sformatf("out_src[%0d]", k), 64'(osrc[k]), 64'(m_src[k]));
         end
         drive(k, mask, p_stb, p_ack);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         g[k]  = model_grant(k, stb[k]);
         ld[k] = rst && (!m_hold[k] || oack[k]) && (g[k] >= 0);
         ea    = '0;
         if (ld[k]) ea[g[k]] = 1'b1;
         check_eq($sformatf("in_ack[%0d]", k), 64'(iack[k]), 64'(ea));
         m_acked[k] = ea;
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            if (ld[k]) begin
               m_data[k] = din[k][g[k]*W +: W];
               m_src[k]  = g[k];
               m_hold[k] = 1'b1;
               if (g[k] == m_last[k]) m_cnt[k] = (m_cnt[k] + 1 > m_mb[k]) ? m_mb[k] : m_cnt[k] + 1;
               else m_cnt[k] = 1;
               m_last[k] = g[k];
            end else if (m_hold[k] && oack[k]) begin
               m_hold[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic check_reset_outputs();
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("rst_out_stb[%0d]", k), 64'(ostb[k]), 64'(0));
         check_eq($sformatf("rst_out_data[%0d]", k), 64'(odat[k]), 64'(0));
         check_eq($sformatf("rst_out_src[%0d]", k), 64'(osrc[k]), 64'(0));
         check_eq($sformatf("rst_in_ack[%0d]", k), 64'(iack[k]), 64'(0));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_mb[0] = 1;
      m_mb[1] = 3;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         stb[k]  = '1;
         din[k]  = {$urandom, $urandom, $urandom, $urandom};
         oack[k] = 1'b1;
         model_reset(k);
      end
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs();
      #1 rst = 1'b1;

      // Only requester 1 active.
      for (int k = 0; k < 2; k++) stb[k] = '0;
      repeat (6)  run_cycle(4'b0010, 100, 100);
      // Everyone requesting continuously: strict rotation on instance a.
      repeat (16) run_cycle(4'b1111, 100, 100);
      // Backpressure then release.
      repeat (5)  run_cycle(4'b1111, 100, 0);
      repeat (4)  run_cycle(4'b1111, 100, 100);
      // Drain, then two continuous requesters to exercise burst hold.
      repeat (6)  run_cycle(4'b0000, 0, 100);
      repeat (12) run_cycle(4'b0101, 100, 100);
      // Random traffic with drops mid-burst and random backpressure.
      repeat (400) run_cycle(4'b1111, 50, 70);

      // Asynchronous reset while words are held.
      repeat (2) run_cycle(4'b1111, 100, 0);
      #2 rst = 1'b0;
      #1;
      check_reset_outputs();
      for (int k = 0; k < 2; k++) model_reset(k);
      run_cycle(4'b1111, 100, 100);
      #1 rst = 1'b1;
      repeat (8)   run_cycle(4'b1111, 100, 100);
      repeat (300) run_cycle(4'b1111, 70, 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_round_robin_arbiter.md
Name: stream_round_robin_arbiter

Overview:
- Shares one 32-bit stb/ack output stream between N requester streams, e.g. several processes driving a single rs232_tx or radio_frequency port.
- Round-robin arbitration, with an optional burst hold that keeps the grant on one requester for up to MAX_BURST consecutive words.
- One registered output stage; sustains one word per cycle when the downstream acks continuously.
- Sits between the per-process output streams and the top-level output port.

Parameters:
- N, 4, number of requester streams (2..16).
- WIDTH, 32, data width of every stream.
- MAX_BURST, 1, maximum consecutive words granted to one requester while its stb stays high; 1 = pure round-robin.
- SRC_W, max(1,clog2(N)), width of the source-index output.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  N*WIDTH  requester data; slice i = [i*WIDTH +: WIDTH].
- in_stb  in  N  requester i holds a valid word.
- in_ack  out  N  word from requester i accepted this cycle.
- out_data  out  WIDTH  registered output word.
- out_stb  out  1  out_data valid.
- out_ack  in  1  downstream accepts out_data.
- out_src  out  SRC_W  index of the requester that supplied out_data.

Behaviour:
- Handshake: a transfer occurs on a rising clk edge when stb and ack are both high. A producer holds stb and data stable until acked.
- States:
  - IDLE: output register empty.
  - SEND: out_stb=1.
- can_load = (state==IDLE) || (state==SEND && out_ack).
- Grant selection (combinational, same cycle):
  - If burst_cnt < MAX_BURST, in_stb[last] is high, and a previous grant exists, then g = last.
  - Otherwise g = first i with in_stb[i] high, searching from (last+1) mod N upward with wrap.
- in_ack[g] = can_load && in_stb[g]. All other in_ack bits are 0. in_ack is combinational from in_stb, state and out_ack.
- On load (any in_ack high):
  - out_data <= in_data[g]; out_src <= g; out_stb <= 1; state <= SEND.
  - If g==last, burst_cnt <= burst_cnt+1 (saturating at MAX_BURST); otherwise burst_cnt <= 1.
  - last <= g.
- SEND with out_ack and no in_stb high: out_stb <= 0, state <= IDLE. last and burst_cnt are held.
- SEND without out_ack: all registers hold and in_ack stays 0 (backpressure).
- Latency: a word accepted at edge t appears on out_stb/out_data after edge t, i.e. 1 cycle. Throughput is 1 word/cycle with out_ack high.
- Burst counter: if requester `last` drops stb, a different requester is granted. burst_cnt resets to 1 on that switch.
- Simultaneous out_ack and new load: the old word and the new word transfer on the same edge; no bubble.
- Reset (rst=0, asynchronous):
  - out_stb=0, out_data=0, out_src=0, state=IDLE.
  - last=N-1, so requester 0 has first priority; burst_cnt=0.
  - A word held in the register is discarded. in_ack is 0 while rst=0.
- N not a power of 2: the pointer wraps at N-1 → 0, never to an unused index.

Decomposition:
- Package stream_arb_pkg:
  - WIDTH default constant.
  - State enum {IDLE, SEND}.
  - clog2 helper function.
- Sub-module rr_priority_select (combinational): inputs req[N] and ptr; outputs grant index and grant_valid. This is the rotate-then-find-first logic, reusable by other arbiters.

Test Plan:
- Single requester: in_stb[1]=1, in_data slice1=0x000000A5, out_ack=1 → in_ack=4'b0010 in that cycle; next cycle out_stb=1, out_data=0x000000A5, out_src=1.
- Fairness: N=4, MAX_BURST=1, all in_stb high continuously with distinct data, out_ack=1 → out_src sequence 0,1,2,3,0,1,… at one word per cycle.
- Backpressure: out_stb=1 and out_ack=0 for 5 cycles with all in_stb high → out_data/out_src stable and in_ack=0 throughout; the first out_ack cycle loads the next requester in the same edge.
- Burst: MAX_BURST=3, in_stb[0] and in_stb[2] high continuously → out_src 0,0,0,2,2,2,0,0,0.
- Early burst end: MAX_BURST=3, requester 0 drops stb after 1 word while 1 and 3 are pending → next out_src=1, then 3.
- Reset mid-operation: rst=0 while out_stb=1 → out_stb=0 immediately, without waiting for clk. After release, with all in_stb high, the first out_src is 0.
